// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(11,7) link: widths, parity positions,
// transmitter FSM states and the reference encoder function.
// Optional build macro HAMMING_TX_ERR_INJ_EN (see hamming_tx.sv).
package hamming_pkg;

   localparam int unsigned DATA_W     = 7;
   localparam int unsigned CODE_W     = 11;
   localparam int unsigned FRAME_BITS = 13;

   localparam int unsigned P1_POS = 1;
   localparam int unsigned P2_POS = 2;
   localparam int unsigned P4_POS = 4;
   localparam int unsigned P8_POS = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Positions are 1-based; code[0] is position 1.
   function automatic logic [CODE_W-1:0] hamming_enc(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      c           = '0;
      c[2]        = d[0];
      c[6:4]      = d[3:1];
      c[10:8]     = d[6:4];
      c[P1_POS-1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c[P2_POS-1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c[P4_POS-1] = d[1] ^ d[2] ^ d[3];
      c[P8_POS-1] = d[4] ^ d[5] ^ d[6];
      return c;
   endfunction

endpackage

// File: rtl/hamming_tx_if.sv
// Input word handshake for the Hamming transmitter.
// With HAMMING_TX_ERR_INJ_EN defined, carries the error-injection position.
interface hamming_tx_if;
   import hamming_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
`ifdef HAMMING_TX_ERR_INJ_EN
   logic [3:0]        inj_pos;
`endif

`ifdef HAMMING_TX_ERR_INJ_EN
   modport master (output in_valid, output in_data, output inj_pos, input in_ready);
   modport slave  (input in_valid, input in_data, input inj_pos, output in_ready);
`else
   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
`endif

endinterface

// File: rtl/hamming_enc_7_11.sv
// Combinational Hamming(11,7) encoder; also usable as a reference model.
module hamming_enc_7_11
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] code
);

   // Pure wrapper around the package encoder.
   always_comb code = hamming_enc(data);

endmodule

// File: rtl/hamming_tx.sv
// Hamming(11,7) serial transmitter: accepts 7-bit words, encodes them and
// sends start bit, code[0]..code[10] LSB first, stop bit.
// Build macro HAMMING_TX_ERR_INJ_EN adds single-bit error injection.
module hamming_tx
   import hamming_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              rst,
   hamming_tx_if.slave       in_if,
   output logic              tx,
   output logic              busy,
   output logic [CODE_W-1:0] code_out,
   output logic              frame_done
);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_param
         $error("hamming_tx: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   localparam int unsigned CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] LAST_BIT = 4'(CODE_W - 1);

   tx_state_t         state_q, state_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [3:0]        bit_q, bit_n;
   logic              tx_q, tx_n;
   logic              done_q, done_n;
   logic [CODE_W-1:0] code_q, code_n;
   logic [CODE_W-1:0] enc_code;
   logic [CODE_W-1:0] inj_mask;
   logic              accept;

   hamming_enc_7_11 u_enc (
      .data (in_if.in_data),
      .code (enc_code)
   );

`ifdef HAMMING_TX_ERR_INJ_EN
   // Single-bit flip mask; out-of-range positions inject nothing.
   always_comb begin
      inj_mask = '0;
      if (in_if.inj_pos >= 4'd1 && in_if.inj_pos <= 4'd11)
         inj_mask = CODE_W'(1) << (in_if.inj_pos - 4'd1);
   end
`else
   // No injection in this build.
   always_comb inj_mask = '0;
`endif

   assign accept          = in_if.in_valid && (state_q == IDLE);
   assign in_if.in_ready  = (state_q == IDLE);
   assign busy            = (state_q != IDLE);
   assign tx              = tx_q;
   assign code_out        = code_q;
   assign frame_done      = done_q;

   // State, counters and registered line/codeword.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         tx_q    <= tx_n;
         done_q  <= done_n;
         code_q  <= code_n;
      end
   end

   // Next state; tx is computed one cycle ahead so the line is a flop output.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      bit_n   = bit_q;
      tx_n    = tx_q;
      done_n  = 1'b0;
      code_n  = code_q;
      unique case (state_q)
         IDLE: begin
            tx_n = 1'b1;
            if (accept) begin
               state_n = START;
               cnt_n   = '0;
               bit_n   = '0;
               tx_n    = 1'b0;
               code_n  = enc_code ^ inj_mask;
            end
         end
         START: begin
            if (cnt_q == CNT_MAX) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = DATA;
               tx_n    = code_q[0];
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_MAX) begin
               cnt_n = '0;
               if (bit_q == LAST_BIT) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_q + 4'd1;
                  tx_n  = code_q[bit_q + 4'd1];
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_MAX) begin
               cnt_n   = '0;
               state_n = IDLE;
               done_n  = 1'b1;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_hamming_tx.sv
// Directed testbench for hamming_tx with CLKS_PER_BIT = 4.
module tb_hamming_tx;

   localparam int unsigned CPB = 4;

   logic        clk;
   logic        rst;
   logic        tx;
   logic        busy;
   logic [10:0] code_out;
   logic        frame_done;

   int unsigned checks = 0;
   int unsigned errors = 0;

   hamming_tx_if in_if ();

   hamming_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_if      (in_if),
      .tx         (tx),
      .busy       (busy),
      .code_out   (code_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a word and pass the accepting edge; returns in frame cycle 1.
   task automatic send(input logic [6:0] d);
      int unsigned n;
      in_if.in_data  = d;
      in_if.in_valid = 1'b1;
      n = 0;
      while (!in_if.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1");
      end
      tick();
      in_if.in_valid = 1'b0;
   endtask

   // Check frame cycles 1..52 bit by bit and frame_done at cycle 53.
   task automatic run_frame(input logic [10:0] code, input bit disturb);
      logic exp_bit;
      int unsigned b;
      for (int unsigned k = 1; k <= 52; k++) begin
         b = (k - 1) / CPB;
         if (b == 0)       exp_bit = 1'b0;
         else if (b == 12) exp_bit = 1'b1;
         else              exp_bit = code[b-1];
         chk($sformatf("tx_c%0d", k), {10'd0, tx}, {10'd0, exp_bit});
         if (k == 20) chk("busy_mid", {10'd0, busy}, 11'd1);
         if (disturb && k >= 10 && k <= 40) begin
            in_if.in_data  = 7'($urandom);
            in_if.in_valid = (k % 3 == 0);
         end else begin
            in_if.in_valid = 1'b0;
         end
         tick();
      end
      chk("frame_done_c53", {10'd0, frame_done}, 11'd1);
      chk("in_ready_c53", {10'd0, in_if.in_ready}, 11'd1);
      chk("code_out_hold", code_out, code);
   endtask

   function automatic logic [3:0] syndrome(input logic [10:0] c);
      logic [3:0] s;
      s = '0;
      for (int unsigned i = 0; i < 11; i++)
         if (c[i]) s = s ^ 4'(i + 1);
      return s;
   endfunction

   initial begin
      int unsigned done_cnt;
      logic [10:0] fixed;
      logic [3:0]  s;

      rst            = 1'b1;
      in_if.in_valid = 1'b0;
      in_if.in_data  = '0;
`ifdef HAMMING_TX_ERR_INJ_EN
      in_if.inj_pos  = '0;
`endif
      tick(); tick(); tick();
      chk("rst_tx", {10'd0, tx}, 11'd1);
      chk("rst_in_ready", {10'd0, in_if.in_ready}, 11'd1);
      chk("rst_busy", {10'd0, busy}, 11'd0);
      chk("rst_code_out", code_out, 11'h000);
      chk("rst_frame_done", {10'd0, frame_done}, 11'd0);
      // reset wins over a simultaneous in_valid
      in_if.in_valid = 1'b1;
      tick();
      chk("rst_vs_valid", {10'd0, busy}, 11'd0);
      in_if.in_valid = 1'b0;
      rst = 1'b0;
      tick();

      send(7'h00);
      chk("enc_00", code_out, 11'h000);
      run_frame(11'h000, 1'b0);
      tick();

      send(7'h7F);
      chk("enc_7F", code_out, 11'h7FF);
      run_frame(11'h7FF, 1'b0);
      tick();

      // 0x01 with in_data/in_valid disturbed mid-frame
      send(7'h01);
      chk("enc_01", code_out, 11'h007);
      run_frame(11'h007, 1'b1);
      tick();
      chk("frame_done_one_cycle", {10'd0, frame_done}, 11'd0);

      // back-to-back with in_valid held high
      in_if.in_data  = 7'h55;
      in_if.in_valid = 1'b1;
      tick();
      chk("enc_55", code_out, 11'h52F);
      in_if.in_data = 7'h2A;
      for (int unsigned k = 1; k <= 52; k++) begin
         chk($sformatf("b2b_ready_c%0d", k), {10'd0, in_if.in_ready}, 11'd0);
         tick();
      end
      chk("b2b_ready_c53", {10'd0, in_if.in_ready}, 11'd1);
      chk("b2b_tx_c53", {10'd0, tx}, 11'd1);
      chk("b2b_done_c53", {10'd0, frame_done}, 11'd1);
      chk("b2b_code_hold", code_out, 11'h52F);
      tick();
      in_if.in_valid = 1'b0;
      chk("enc_2A", code_out, 11'h2D0);
      chk("b2b_start_bit", {10'd0, tx}, 11'd0);

      // reset while code[5] (a 0) is on the line
      for (int unsigned k = 0; k < 25; k++) tick();
      chk("pre_rst_tx", {10'd0, tx}, 11'd0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", {10'd0, tx}, 11'd1);
      chk("midrst_busy", {10'd0, busy}, 11'd0);
      chk("midrst_code", code_out, 11'h000);
      tick();
      rst = 1'b0;
      done_cnt = 0;
      for (int unsigned k = 0; k < 60; k++) begin
         if (frame_done) done_cnt++;
         tick();
      end
      chk("midrst_no_done", 11'(done_cnt), 11'd0);
      chk("midrst_idle_tx", {10'd0, tx}, 11'd1);
      send(7'h01);
      chk("post_rst_enc", code_out, 11'h007);
      run_frame(11'h007, 1'b0);
      tick();

`ifdef HAMMING_TX_ERR_INJ_EN
      in_if.inj_pos = 4'd3;
      send(7'h01);
      chk("inj3_code", code_out, 11'h003);
      s = syndrome(code_out);
      chk("inj3_syndrome", {7'd0, s}, 11'd3);
      fixed = code_out;
      if (s >= 4'd1 && s <= 4'd11) fixed[s - 4'd1] = ~fixed[s - 4'd1];
      chk("inj3_corrected", fixed, 11'h007);
      run_frame(11'h003, 1'b0);
      tick();
      in_if.inj_pos = 4'd12;
      send(7'h01);
      chk("inj12_code", code_out, 11'h007);
      run_frame(11'h007, 1'b0);
      tick();
      in_if.inj_pos = 4'd0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
